// File: rtl/axi_beat_addr_gen.sv
// axi_beat_addr_gen: expands one AXI AW/AR command into per-beat address, strobe, index and last flag
module axi_beat_addr_gen #(
    parameter int C_AXI_ID_WIDTH   = 6,
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_LEN_WIDTH  = 4
) (
    input  logic                        ACLK,
    input  logic                        ARESETn,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [C_AXI_ID_WIDTH-1:0]   cmd_id,
    input  logic [C_AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [C_AXI_LEN_WIDTH-1:0]  cmd_len,
    input  logic [2:0]                  cmd_size,
    input  logic [1:0]                  cmd_burst,
    output logic                        beat_valid,
    input  logic                        beat_ready,
    output logic [C_AXI_ID_WIDTH-1:0]   beat_id,
    output logic [C_AXI_ADDR_WIDTH-1:0] beat_addr,
    output logic [C_AXI_DATA_WIDTH/8-1:0] beat_strb,
    output logic [C_AXI_LEN_WIDTH-1:0]  beat_idx,
    output logic                        beat_last,
    output logic                        cmd_err,
    output logic [C_AXI_ID_WIDTH-1:0]   cmd_err_id
);
    localparam int IW  = C_AXI_ID_WIDTH;
    localparam int AW  = C_AXI_ADDR_WIDTH;
    localparam int AW1 = C_AXI_ADDR_WIDTH + 1;
    localparam int LW  = C_AXI_LEN_WIDTH;
    localparam int NB  = C_AXI_DATA_WIDTH / 8;

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state_q, state_d;
    logic          valid_q, valid_d, last_q, last_d, err_q, err_d;
    logic [IW-1:0] id_q, id_d, err_id_q, err_id_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [NB-1:0] strb_q, strb_d;
    logic [LW-1:0] idx_q, idx_d, len_q, len_d;
    logic [2:0]    size_q, size_d;
    logic [1:0]    burst_q, burst_d;

    logic [AW-1:0]  c_bytes, c_aligned, n_bytes, n_wsz, n_inc, n_wrap, n_addr;
    logic [AW1-1:0] c_end;
    logic           c_illegal, hs, acc;

    // Lanes from the beat address up to the end of its size-aligned container.
    function automatic logic [NB-1:0] lane_mask(input logic [AW-1:0] a, input logic [2:0] sz);
        logic [AW-1:0] b;
        logic [NB-1:0] m;
        int lo, hi;
        b  = AW'(1) << sz;
        lo = int'(a & AW'(NB - 1));
        hi = int'(((a & ~(b - AW'(1))) + b - AW'(1)) & AW'(NB - 1));
        for (int i = 0; i < NB; i++) m[i] = (i >= lo) && (i <= hi);
        return m;
    endfunction

    assign c_bytes   = AW'(1) << cmd_size;
    assign c_aligned = cmd_addr & ~(c_bytes - AW'(1));
    assign c_end     = {1'b0, c_aligned & AW'(12'hFFF)} + AW1'(c_bytes) * (AW1'(cmd_len) + AW1'(1));
    assign c_illegal = (cmd_burst == 2'b11)
                     | (c_bytes > AW'(NB))
                     | ((cmd_burst == 2'b10) & !(32'(cmd_len) inside {32'd1, 32'd3, 32'd7, 32'd15}))
                     | ((cmd_burst == 2'b10) & ((cmd_addr & (c_bytes - AW'(1))) != '0))
                     | ((cmd_burst != 2'b01) & (32'(cmd_len) > 32'd15))
                     | ((cmd_burst == 2'b01) & (c_end > AW1'(4096)));

    // WRAP wraps to the window base when the incremented address hits the window end.
    assign n_bytes = AW'(1) << size_q;
    assign n_wsz   = n_bytes * (AW'(len_q) + AW'(1));
    assign n_inc   = (addr_q & ~(n_bytes - AW'(1))) + n_bytes;
    assign n_wrap  = (((addr_q + n_bytes) & (n_wsz - AW'(1))) == '0) ? (addr_q & ~(n_wsz - AW'(1))) : addr_q + n_bytes;
    assign n_addr  = (burst_q == 2'b00) ? addr_q : (burst_q == 2'b10) ? n_wrap : n_inc;

    assign hs        = valid_q & beat_ready;
    assign cmd_ready = ARESETn & ((state_q == IDLE) | ((state_q == BURST) & hs & last_q));
    assign acc       = cmd_valid & cmd_ready;

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        last_d   = last_q;
        err_d    = 1'b0;
        err_id_d = err_id_q;
        id_d     = id_q;
        addr_d   = addr_q;
        strb_d   = strb_q;
        idx_d    = idx_q;
        len_d    = len_q;
        size_d   = size_q;
        burst_d  = burst_q;
        if (acc && c_illegal) begin
            state_d  = IDLE;
            valid_d  = 1'b0;
            err_d    = 1'b1;
            err_id_d = cmd_id;
        end else if (acc) begin
            state_d = BURST;
            valid_d = 1'b1;
            id_d    = cmd_id;
            addr_d  = cmd_addr;
            len_d   = cmd_len;
            size_d  = cmd_size;
            burst_d = cmd_burst;
            idx_d   = '0;
            last_d  = (cmd_len == '0);
            strb_d  = lane_mask(cmd_addr, cmd_size);
        end else if (hs && last_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end else if (hs) begin
            addr_d = n_addr;
            idx_d  = idx_q + LW'(1);
            last_d = ((idx_q + LW'(1)) == len_q);
            strb_d = lane_mask(n_addr, size_q);
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
            err_id_q <= '0;
            id_q     <= '0;
            addr_q   <= '0;
            strb_q   <= '0;
            idx_q    <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            err_q    <= err_d;
            err_id_q <= err_id_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            strb_q   <= strb_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            size_q   <= size_d;
            burst_q  <= burst_d;
        end
    end

    assign beat_valid = valid_q;
    assign beat_id    = id_q;
    assign beat_addr  = addr_q;
    assign beat_strb  = strb_q;
    assign beat_idx   = idx_q;
    assign beat_last  = last_q;
    assign cmd_err    = err_q;
    assign cmd_err_id = err_id_q;
endmodule

// File: tb/tb_axi_beat_addr_gen.sv
// tb_axi_beat_addr_gen: vector table, directed corner sequences and random commands against a reference model
module tb_axi_beat_addr_gen;
    logic        ACLK, ARESETn;
    logic        cmd_valid, cmd_ready;
    logic [5:0]  cmd_id;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic        beat_valid, beat_ready;
    logic [5:0]  beat_id;
    logic [31:0] beat_addr;
    logic [3:0]  beat_strb;
    logic [7:0]  beat_idx;
    logic        beat_last, cmd_err;
    logic [5:0]  cmd_err_id;

    int checks = 0;
    int errors = 0;

    axi_beat_addr_gen #(
        .C_AXI_ID_WIDTH(6), .C_AXI_ADDR_WIDTH(32), .C_AXI_DATA_WIDTH(32), .C_AXI_LEN_WIDTH(8)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
        .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_id(beat_id), .beat_addr(beat_addr),
        .beat_strb(beat_strb), .beat_idx(beat_idx), .beat_last(beat_last),
        .cmd_err(cmd_err), .cmd_err_id(cmd_err_id)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct { logic [31:0] addr; logic [3:0] strb; } beat_t;
    typedef struct { logic [31:0] addr; int len; int sz; int bst; bit err; logic [31:0] a0; logic [3:0] s0; int n; } vec_t;

    beat_t exp_q[$];
    vec_t  vt[13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: legality from the protocol rules, beats from closed-form address arithmetic.
    task automatic build_model(input logic [31:0] a, input int len, input int sz, input int bst, output bit err);
        longint bytes, al, total, lower, ba;
        beat_t  b;
        bytes = longint'(1) << sz;
        al    = (longint'(a) / bytes) * bytes;
        total = bytes * (len + 1);
        err = (bst == 3) || (bytes > 4)
           || (bst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15))
           || (bst == 2 && (longint'(a) % bytes) != 0)
           || (bst != 1 && len > 15)
           || (bst == 1 && (al >> 12) != ((al + total - 1) >> 12));
        exp_q.delete();
        if (!err) begin
            lower = (longint'(a) / total) * total;
            for (int n = 0; n <= len; n++) begin
                if (bst == 0) ba = longint'(a);
                else if (bst == 1) ba = (n == 0) ? longint'(a) : al + n * bytes;
                else ba = lower + ((longint'(a) - lower + n * bytes) % total);
                b.addr = 32'(ba);
                b.strb = '0;
                for (longint x = ba; x < (ba / bytes) * bytes + bytes; x++) b.strb[x % 4] = 1'b1;
                exp_q.push_back(b);
            end
        end
    endtask

    // Entered and left one time unit after a rising edge with the FSM idle.
    task automatic do_cmd(input logic [31:0] a, input int len, input int sz, input int bst, input logic [5:0] id,
                          input bit rnd, output bit got_err, output logic [31:0] a0, output logic [3:0] s0, output int nb);
        bit merr, rdy;
        int cyc;
        build_model(a, len, sz, bst, merr);
        beat_ready = 1'b0;
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = 8'(len); cmd_size = 3'(sz); cmd_burst = 2'(bst); cmd_id = id;
        #1;
        chk("cmd_ready_idle", cmd_ready, 1);
        @(posedge ACLK); #1;
        cmd_valid = 1'b0;
        got_err = cmd_err; a0 = '0; s0 = '0; nb = 0;
        chk("err_flag", cmd_err, merr);
        if (merr) begin
            chk("err_id", cmd_err_id, id);
            chk("err_no_beat", beat_valid, 0);
            @(posedge ACLK); #1;
            chk("err_pulse_end", cmd_err, 0);
            chk("err_no_beat2", beat_valid, 0);
        end else begin
            a0 = beat_addr; s0 = beat_strb; cyc = 0;
            while (nb < exp_q.size() && cyc < 4000) begin
                chk("beat_valid", beat_valid, 1);
                if (beat_valid !== 1'b1) break;
                chk($sformatf("addr[%0d]", nb), beat_addr, exp_q[nb].addr);
                chk($sformatf("strb[%0d]", nb), beat_strb, exp_q[nb].strb);
                chk($sformatf("idx[%0d]", nb), beat_idx, nb);
                chk($sformatf("last[%0d]", nb), beat_last, nb == len);
                chk($sformatf("id[%0d]", nb), beat_id, id);
                rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                beat_ready = rdy;
                @(posedge ACLK); #1;
                cyc++;
                if (rdy) nb++;
            end
            beat_ready = 1'b0;
            chk("beat_count", nb, exp_q.size());
            chk("idle_after", beat_valid, 0);
        end
    endtask

    initial begin
        bit          e;
        logic [31:0] a0, a;
        logic [3:0]  s0;
        int          nb, len, sz, bst;

        vt[0]  = '{32'h1001, 2,   2, 1, 0, 32'h1001, 4'hE, 3};
        vt[1]  = '{32'h001C, 3,   2, 2, 0, 32'h001C, 4'hF, 4};
        vt[2]  = '{32'h001E, 3,   2, 2, 1, 0, 0, 0};
        vt[3]  = '{32'h0043, 3,   0, 0, 0, 32'h0043, 4'h8, 4};
        vt[4]  = '{32'h0000, 0,   3, 1, 1, 0, 0, 0};
        vt[5]  = '{32'h0FF8, 3,   2, 1, 1, 0, 0, 0};
        vt[6]  = '{32'h0000, 255, 0, 1, 0, 32'h0000, 4'h1, 256};
        vt[7]  = '{32'h0000, 16,  2, 0, 1, 0, 0, 0};
        vt[8]  = '{32'h0100, 1,   2, 3, 1, 0, 0, 0};
        vt[9]  = '{32'h0100, 2,   2, 2, 1, 0, 0, 0};
        vt[10] = '{32'h0FF8, 1,   2, 1, 0, 32'h0FF8, 4'hF, 2};
        vt[11] = '{32'h1000, 7,   1, 2, 0, 32'h1000, 4'h3, 8};
        vt[12] = '{32'h1006, 1,   1, 1, 0, 32'h1006, 4'hC, 2};

        ARESETn = 1'b0; cmd_valid = 1'b0; beat_ready = 1'b0;
        cmd_id = '0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;
        repeat (2) @(posedge ACLK);
        #1;
        chk("rst_valid", beat_valid, 0);
        chk("rst_err", cmd_err, 0);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_last", beat_last, 0);
        chk("rst_addr", beat_addr, 0);
        ARESETn = 1'b1;
        #1;
        chk("rel_ready", cmd_ready, 1);
        @(posedge ACLK); #1;

        for (int i = 0; i < 13; i++) begin
            do_cmd(vt[i].addr, vt[i].len, vt[i].sz, vt[i].bst, 6'(i + 1), i % 2 == 1, e, a0, s0, nb);
            chk($sformatf("vec%0d_err", i), e, vt[i].err);
            if (!vt[i].err) begin
                chk($sformatf("vec%0d_a0", i), a0, vt[i].a0);
                chk($sformatf("vec%0d_s0", i), s0, vt[i].s0);
                chk($sformatf("vec%0d_n", i), nb, vt[i].n);
            end
        end

        // Chaining: second command accepted on the last-beat handshake of the first.
        cmd_valid = 1'b1; cmd_addr = 32'h3000; cmd_len = 8'd1; cmd_size = 3'd2; cmd_burst = 2'd1; cmd_id = 6'd5;
        @(posedge ACLK); #1;
        cmd_valid = 1'b0;
        chk("chainA_b0", beat_addr, 32'h3000);
        beat_ready = 1'b1;
        @(posedge ACLK); #1;
        chk("chainA_b1", beat_addr, 32'h3004);
        chk("chainA_last", beat_last, 1);
        cmd_valid = 1'b1; cmd_addr = 32'h3100; cmd_len = 8'd2; cmd_id = 6'd6;
        #1;
        chk("chain_ready", cmd_ready, 1);
        @(posedge ACLK); #1;
        cmd_valid = 1'b0;
        chk("chainB_valid", beat_valid, 1);
        chk("chainB_addr", beat_addr, 32'h3100);
        chk("chainB_idx", beat_idx, 0);
        chk("chainB_id", beat_id, 6);
        @(posedge ACLK); #1;
        chk("chainB_b1", beat_addr, 32'h3104);
        @(posedge ACLK); #1;
        chk("chainB_b2", beat_addr, 32'h3108);
        chk("chainB_last", beat_last, 1);
        @(posedge ACLK); #1;
        beat_ready = 1'b0;
        chk("chain_done", beat_valid, 0);

        for (int i = 0; i < 80; i++) begin
            bst = $urandom_range(0, 3);
            sz  = ($urandom_range(0, 9) == 0) ? $urandom_range(3, 7) : $urandom_range(0, 2);
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
            if (bst == 2 && $urandom_range(0, 3) != 0) len = (2 << $urandom_range(0, 3)) - 1;
            a = $urandom();
            if ($urandom_range(0, 1) == 1) a[11:0] = 12'hFC0 | 12'($urandom_range(0, 63));
            if (bst == 2 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            do_cmd(a, len, sz, bst, 6'($urandom()), 1'b1, e, a0, s0, nb);
        end

        do_cmd(32'h10, 0, 2, 3, 6'h2A, 1'b0, e, a0, s0, nb);

        // Reset in the middle of a len=7 burst.
        cmd_valid = 1'b1; cmd_addr = 32'h2000; cmd_len = 8'd7; cmd_size = 3'd2; cmd_burst = 2'd1; cmd_id = 6'd9;
        @(posedge ACLK); #1;
        cmd_valid = 1'b0;
        beat_ready = 1'b1;
        @(posedge ACLK); #1;
        @(posedge ACLK); #1;
        chk("mid_idx", beat_idx, 2);
        ARESETn = 1'b0; beat_ready = 1'b0;
        @(posedge ACLK); #1;
        chk("mrst_valid", beat_valid, 0);
        chk("mrst_addr", beat_addr, 0);
        chk("mrst_id", beat_id, 0);
        chk("mrst_idx", beat_idx, 0);
        chk("mrst_strb", beat_strb, 0);
        chk("mrst_last", beat_last, 0);
        chk("mrst_err", cmd_err, 0);
        chk("mrst_err_id", cmd_err_id, 0);
        chk("mrst_ready", cmd_ready, 0);
        ARESETn = 1'b1;
        #1;
        chk("mrel_ready", cmd_ready, 1);
        @(posedge ACLK); #1;
        chk("mrel_idle", beat_valid, 0);
        do_cmd(32'h2000, 3, 2, 1, 6'd11, 1'b0, e, a0, s0, nb);
        chk("post_rst_n", nb, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
